// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared types for the hex display scheduler.
// FSM states, requester ids, AXI constants and the arbiter pick.
package hex_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP
  } hex_sched_state_t;

  typedef enum logic {
    REQ_PERF,
    REQ_SW
  } hex_req_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0] AXI_PROT_DEF  = 3'b000;

  // Round-robin pick; the caller qualifies with "any request".
  function automatic hex_req_t rr_pick(
    input logic     perf,
    input logic     sw,
    input hex_req_t last
  );
    hex_req_t r;
    r = REQ_PERF;
    unique case (1'b1)
      (perf && sw):  r = (last == REQ_SW) ? REQ_PERF : REQ_SW;
      (sw && !perf): r = REQ_SW;
      default:       r = REQ_PERF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hex_refresh_timer.sv
// hex_refresh_timer: free-running 0..PERIOD-1 counter.
// wrap is high during the last count of each period.
module hex_refresh_timer
  import hex_disp_pkg::*;
#(
  parameter int unsigned PERIOD = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic wrap
);

  localparam int unsigned CW =
    (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  assign wrap = (cnt == LAST);

  // count up, fold back to zero after the last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hex_disp_sched.sv
// hex_disp_sched: round-robin AXI-lite writer for the hex display.
// Define HEX_WR_TIMEOUT_EN to abort stalled writes after TIMEOUT_CYCLES.
module hex_disp_sched
  import hex_disp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] HEX_BASE_ADDR = '0,
  parameter int unsigned REFRESH_CYCLES = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] perf_cnt,
  input  logic                  sw_valid,
  output logic                  sw_ready,
  input  logic [DATA_WIDTH-1:0] sw_data,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic                  busy,
  output logic                  err
);

  if (DATA_WIDTH != 32 || REFRESH_CYCLES < 2) begin : g_cfg_bad
    $error("hex_disp_sched: unsupported width or refresh period");
  end

  if (TIMEOUT_CYCLES < 1) begin : g_to_bad
    $error("hex_disp_sched: TIMEOUT_CYCLES must be at least 1");
  end

  hex_sched_state_t      state;
  hex_sched_state_t      state_d;
  hex_req_t              rr_last;
  hex_req_t              pick;
  logic                  wrap;
  logic                  perf_pend;
  logic                  req_any;
  logic                  gnt;
  logic                  gnt_sw;
  logic                  gnt_perf;
  logic                  aw_q;
  logic                  aw_d;
  logic                  w_q;
  logic                  w_d;
  logic                  err_q;
  logic                  err_d;
  logic                  to_hit;
  logic [DATA_WIDTH-1:0] wdata_q;

  hex_refresh_timer #(
    .PERIOD (REFRESH_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .wrap  (wrap)
  );

  // arbitrate only in IDLE; reset masks the sw_ready pulse
  always_comb begin
    pick     = rr_pick(perf_pend, sw_valid, rr_last);
    req_any  = perf_pend | sw_valid;
    gnt      = rst_n & (state == IDLE) & req_any;
    gnt_sw   = gnt & (pick == REQ_SW);
    gnt_perf = gnt & (pick == REQ_PERF);
  end

`ifdef HEX_WR_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;

  assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // cycles spent in ADDR/RESP for the current write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // next state, channel valids and sticky error
  always_comb begin
    state_d = state;
    aw_d    = aw_q;
    w_d     = w_q;
    err_d   = err_q;
    unique case (state)
      IDLE: begin
        if (gnt) begin
          state_d = ADDR;
          aw_d    = 1'b1;
          w_d     = 1'b1;
        end
      end
      ADDR: begin
        aw_d = aw_q & ~m_axil_awready;
        w_d  = w_q & ~m_axil_wready;
        if (to_hit) begin
          err_d   = 1'b1;
          aw_d    = 1'b0;
          w_d     = 1'b0;
          state_d = IDLE;
        end else if (!aw_d && !w_d) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (m_axil_bvalid) begin
          state_d = IDLE;
          if (m_axil_bresp != AXI_RESP_OKAY) begin
            err_d = 1'b1;
          end
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        aw_d    = 1'b0;
        w_d     = 1'b0;
      end
    endcase
  end

  // FSM and AXI valid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      aw_q  <= 1'b0;
      w_q   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      aw_q  <= aw_d;
      w_q   <= w_d;
      err_q <= err_d;
    end
  end

  // pending perf sample; a wrap beats a same-cycle grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_pend <= 1'b0;
    end else if (wrap) begin
      perf_pend <= 1'b1;
    end else if (gnt_perf) begin
      perf_pend <= 1'b0;
    end
  end

  // capture the winner's word and remember who won
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= REQ_SW;
      wdata_q <= '0;
    end else if (gnt) begin
      rr_last <= pick;
      wdata_q <= gnt_sw ? sw_data : perf_cnt;
    end
  end

  assign sw_ready       = gnt_sw;
  assign m_axil_awaddr  = HEX_BASE_ADDR;
  assign m_axil_awprot  = AXI_PROT_DEF;
  assign m_axil_awvalid = aw_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = '1;
  assign m_axil_wvalid  = w_q;
  assign m_axil_bready  = (state == RESP);
  assign busy           = (state != IDLE);
  assign err            = err_q;

endmodule

// File: tb/tb_hex_disp_sched.sv
// tb_hex_disp_sched: scoreboard bench for the hex display scheduler.
// Stimulus pushes expected writes; a negedge monitor pops and compares.
module tb_hex_disp_sched;

  localparam logic [15:0] BASE = 16'h0040;
  localparam int RC = 8;
  localparam int TC = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] perf_cnt = '0;
  logic        sw_valid = 1'b0;
  logic        sw_ready;
  logic [31:0] sw_data = '0;
  logic [15:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid;
  logic        bready;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel = 0;

  hex_disp_sched #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (16),
    .STRB_WIDTH     (4),
    .HEX_BASE_ADDR  (BASE),
    .REFRESH_CYCLES (RC),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .perf_cnt       (perf_cnt),
    .sw_valid       (sw_valid),
    .sw_ready       (sw_ready),
    .sw_data        (sw_data),
    .m_axil_awaddr  (awaddr),
    .m_axil_awprot  (awprot),
    .m_axil_awvalid (awvalid),
    .m_axil_awready (awready),
    .m_axil_wdata   (wdata),
    .m_axil_wstrb   (wstrb),
    .m_axil_wvalid  (wvalid),
    .m_axil_wready  (wready),
    .m_axil_bresp   (bresp),
    .m_axil_bvalid  (bvalid),
    .m_axil_bready  (bready),
    .busy           (busy),
    .err            (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // slave: W always ready, AW after aw_delay waits, B one cycle later
  int   aw_delay = 0;
  logic b_en = 1'b1;
  int   aw_wait;
  logic aw_got;
  logic w_got;

  assign awready = (aw_wait >= aw_delay);
  assign wready  = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      if (awvalid && !awready) aw_wait <= aw_wait + 1;
      else if (awvalid && awready) aw_wait <= 0;
      if (awvalid && awready) aw_got <= 1'b1;
      if (wvalid && wready) w_got <= 1'b1;
      if (!b_en) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else if (aw_got && w_got && !bvalid) begin
        bvalid <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (bvalid && bready) bvalid <= 1'b0;
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t        exq[$];
  exp_t        e;
  logic        aw_seen;
  logic        w_seen;
  logic        aw_hold;
  logic        w_hold;
  logic [15:0] cap_a;
  logic [15:0] hold_a;
  logic [31:0] cap_d;
  logic [31:0] hold_d;
  logic        busy_p;
  logic        chk_busy = 1'b0;
  int          wr_n = 0;
  int          bhs = 0;
  int          swr = 0;
  int          brun = 0;
  int          wr_at[256];

  // monitor: AXI stability, write scoreboard, busy run length
  always @(negedge clk) begin
    if (!rst_n) begin
      aw_seen = 1'b0;
      w_seen  = 1'b0;
      aw_hold = 1'b0;
      w_hold  = 1'b0;
      busy_p  = 1'b0;
      brun    = 0;
    end else begin
      if (aw_hold) begin
        checks++;
        if (!awvalid || awaddr !== hold_a) begin
          errors++;
          $display("FAIL aw_stable awvalid=%b addr=%h required 1/%h",
                   awvalid, awaddr, hold_a);
        end
      end
      if (w_hold) begin
        checks++;
        if (!wvalid || wdata !== hold_d) begin
          errors++;
          $display("FAIL w_stable wvalid=%b data=%h required 1/%h",
                   wvalid, wdata, hold_d);
        end
      end
      if (w_seen) begin
        checks++;
        if (wvalid) begin
          errors++;
          $display("FAIL wvalid_after_hs wvalid=1 required 0");
        end
      end
      if (aw_seen) begin
        checks++;
        if (awvalid) begin
          errors++;
          $display("FAIL awvalid_after_hs awvalid=1 required 0");
        end
      end
      aw_hold = awvalid && !awready;
      hold_a  = awaddr;
      w_hold  = wvalid && !wready;
      hold_d  = wdata;
      if (awvalid && awready) begin
        aw_seen = 1'b1;
        cap_a   = awaddr;
      end
      if (wvalid && wready) begin
        w_seen = 1'b1;
        cap_d  = wdata;
      end
      if (aw_seen && w_seen) begin
        if (wr_n < 256) wr_at[wr_n] = cyc;
        wr_n++;
        checks++;
        if (exq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h", cap_a, cap_d);
        end else begin
          e = exq.pop_front();
          if (cap_a !== e.a || cap_d !== e.d) begin
            errors++;
            $display("FAIL write addr=%h data=%h required %h/%h",
                     cap_a, cap_d, e.a, e.d);
          end
        end
        aw_seen = 1'b0;
        w_seen  = 1'b0;
      end
      if (bvalid && bready) bhs++;
      if (sw_ready) swr++;
      if (busy) begin
        brun++;
      end else begin
        if (busy_p && chk_busy) begin
          checks++;
          if (brun != 3) begin
            errors++;
            $display("FAIL busy_len actual=%0d required=3", brun);
          end
        end
        brun = 0;
      end
      busy_p = busy;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d);
    exp_t x;
    x.a = BASE;
    x.d = d;
    exq.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_bready", 32'(bready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_sw_ready", 32'(sw_ready), 0);
    chk("rst_awaddr", 32'(awaddr), 32'(BASE));
    chk("rst_wstrb", 32'(wstrb), 32'hF);
    chk("rst_awprot", 32'(awprot), 0);
    chk("rst_wdata", wdata, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel = cyc;
  endtask

  task automatic wait_wr(input int n, input int budget, input string nm);
    int k = 0;
    while (wr_n < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (wr_n < n) begin
      errors++;
      $display("FAIL %s writes=%0d required=%0d", nm, wr_n, n);
    end
  endtask

  task automatic wait_b(input int n, input int budget, input string nm);
    int k = 0;
    while (bhs < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (bhs < n) begin
      errors++;
      $display("FAIL %s bresp_hs=%0d required=%0d", nm, bhs, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base;
    int bb;
    int sb;
    int k;
    logic [31:0] arb[10];

    // periodic perf refresh
    chk_busy = 1'b1;
    perf_cnt = 32'hDEADBEEF;
    do_reset();
    base = wr_n;
    repeat (3) push_exp(32'hDEADBEEF);
    wait_wr(base + 3, 60, "p1_writes");
    chk("p1_first_at", wr_at[base] - rel, RC + 1);
    chk("p1_gap1", wr_at[base + 1] - wr_at[base], RC);
    chk("p1_gap2", wr_at[base + 2] - wr_at[base + 1], RC);

    // sw held against periodic perf: SW SW then alternate
    sw_data  = 32'h12345678;
    sw_valid = 1'b1;
    do_reset();
    base = wr_n;
    sb   = swr;
    arb = '{32'h12345678, 32'h12345678, 32'hDEADBEEF, 32'h12345678,
            32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678,
            32'hDEADBEEF, 32'h12345678};
    for (int i = 0; i < 10; i++) push_exp(arb[i]);
    wait_wr(base + 10, 80, "p2_writes");
    sw_valid = 1'b0;
    chk("p2_sw_ready", swr - sb, 6);
    chk("p2_first_at", wr_at[base] - rel, 1);
    chk("p2_last_at", wr_at[base + 9] - rel, 37);

    // W accepted three cycles ahead of AW
    chk_busy = 1'b0;
    aw_delay = 3;
    sw_data  = 32'hA5A50001;
    sw_valid = 1'b1;
    do_reset();
    base = wr_n;
    bb   = bhs;
    sb   = swr;
    push_exp(32'hA5A50001);
    @(posedge clk);
    #1;
    sw_valid = 1'b0;
    wait_b(bb + 1, 30, "p3_b");
    chk("p3_bhs", bhs - bb, 1);
    chk("p3_wr_at", wr_at[base] - rel, 4);
    chk("p3_sw_ready", swr - sb, 1);

    // SLVERR sets sticky err
    aw_delay = 0;
    chk_busy = 1'b1;
    perf_cnt = 32'h000000A5;
    bresp    = 2'b10;
    do_reset();
    bb = bhs;
    repeat (3) push_exp(32'h000000A5);
    wait_b(bb + 1, 40, "p4_b1");
    chk("p4_err_set", 32'(err), 1);
    bresp = 2'b00;
    wait_b(bb + 3, 40, "p4_b3");
    chk("p4_err_sticky", 32'(err), 1);

    // reset in the middle of ADDR
    chk_busy = 1'b0;
    aw_delay = 5;
    perf_cnt = 32'h00005A5A;
    do_reset();
    k = 0;
    while (!awvalid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("p5_awvalid_up", 32'(awvalid), 1);
    @(posedge clk);
    #1;
    chk("p5_awvalid_hold", 32'(awvalid), 1);
    chk("p5_busy", 32'(busy), 1);
    do_reset();
    aw_delay = 0;
    base = wr_n;
    push_exp(32'h00005A5A);
    wait_wr(base + 1, 30, "p5_writes");
    chk("p5_first_at", wr_at[base] - rel, RC + 1);

`ifdef HEX_WR_TIMEOUT_EN
    // B never arrives: abort after TC cycles, then serve the next request
    b_en     = 1'b0;
    perf_cnt = 32'hC0DE0001;
    do_reset();
    base = wr_n;
    bb   = bhs;
    push_exp(32'hC0DE0001);
    push_exp(32'hC0DE0001);
    k = 0;
    while (!busy && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("p6_enter_at", cyc - rel, RC + 1);
    repeat (TC - 1) begin
      @(posedge clk);
      #1;
    end
    chk("p6_busy_last", 32'(busy), 1);
    chk("p6_err_before", 32'(err), 0);
    @(posedge clk);
    #1;
    chk("p6_idle", 32'(busy), 0);
    chk("p6_err", 32'(err), 1);
    b_en = 1'b1;
    wait_wr(base + 2, 30, "p6_writes");
    wait_b(bb + 1, 30, "p6_b");
    chk("p6_err_kept", 32'(err), 1);
`endif

    chk("sb_empty", exq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
